if_fetch_stage: RTL and testbench

- Instruction-fetch stage: owns the PC, issues requests to instruction memory over a valid/ready request channel with a single outstanding transaction, and drives the IF/ID pipeline register (if_id_pc, if_id_instr) consumed by the decode stage.
- Handles hazard-unit stall and EX-stage redirect (branch/jump/jalr target).
- Any in-flight fetch made stale by a redirect is discarded.

---
 rtl/if_pkg.sv | 15 +
 rtl/if_fetch_stage.sv | 127 ++++++++++++
 tb/tb_if_fetch_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Definitions shared by the fetch stage, decode stage and hazard unit:
// fetch FSM states plus the bubble encoding and default reset PC.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no request outstanding
        WAIT = 2'd1,  // request outstanding, response wanted
        DROP = 2'd2,  // request outstanding, response is stale
        HOLD = 2'd3   // response parked until stall drops
    } if_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in
// flight and fills the IF/ID register, honouring stall and EX redirects.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    if_state_e   state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] fetch_pc_reg;
    logic [31:0] hold_pc_reg, hold_instr_reg;
    logic        hold_load;
    logic [31:0] if_id_pc_next, if_id_instr_next;
    logic        if_id_valid_next;
    logic        in_flight, rsp_cycle, req_fire;

    assign in_flight = (state_reg == WAIT) || (state_reg == DROP);
    assign rsp_cycle = in_flight && imem_rsp_valid;

    // A new request may go out in the very cycle the previous response lands.
    assign imem_req_valid = !redirect && !stall && ((state_reg == IDLE) || rsp_cycle);
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign imem_addr      = pc_reg;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        hold_load        = 1'b0;
        if_id_pc_next    = if_id_pc;
        if_id_instr_next = if_id_instr;
        if_id_valid_next = if_id_valid;

        if (redirect) begin
            pc_next          = {redirect_pc[31:2], 2'b00};
            if_id_pc_next    = 32'h0;
            if_id_instr_next = NOP_INSTR;
            if_id_valid_next = 1'b0;
            // Only a request whose response has not yet arrived must be drained.
            state_next       = (in_flight && !imem_rsp_valid) ? DROP : IDLE;
        end else begin
            if (req_fire) begin
                pc_next = pc_reg + 32'd4;
            end
            if (!stall) begin
                if_id_pc_next    = 32'h0;
                if_id_instr_next = NOP_INSTR;
                if_id_valid_next = 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (req_fire) state_next = WAIT;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (stall) begin
                            hold_load  = 1'b1;
                            state_next = HOLD;
                        end else begin
                            if_id_pc_next    = fetch_pc_reg;
                            if_id_instr_next = imem_rsp_data;
                            if_id_valid_next = 1'b1;
                            state_next       = req_fire ? WAIT : IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) state_next = req_fire ? WAIT : IDLE;
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_pc_next    = hold_pc_reg;
                        if_id_instr_next = hold_instr_reg;
                        if_id_valid_next = 1'b1;
                        state_next       = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            fetch_pc_reg   <= 32'h0;
            hold_pc_reg    <= 32'h0;
            hold_instr_reg <= 32'h0;
            if_id_pc       <= 32'h0;
            if_id_instr    <= NOP_INSTR;
            if_id_valid    <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (req_fire) begin
                fetch_pc_reg <= pc_reg;
            end
            if (redirect) begin
                hold_pc_reg    <= 32'h0;
                hold_instr_reg <= 32'h0;
            end else if (hold_load) begin
                hold_pc_reg    <= fetch_pc_reg;
                hold_instr_reg <= imem_rsp_data;
            end
            if_id_pc    <= if_id_pc_next;
            if_id_instr <= if_id_instr_next;
            if_id_valid <= if_id_valid_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed per-cycle table plus randomized run
// checked against an instruction-stream model and a latency-configurable memory.
module tb_if_fetch_stage;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid)
    );

    int n_vec = 0;
    int n_bad = 0;

    // memory model: one pending request, response after 'lat' cycles
    bit          mem_pend = 0;
    int          mem_cnt  = 0;
    logic [31:0] mem_data = 32'h0;

    // stream model: next PC the program order says must be delivered
    logic [31:0] exp_pc;
    logic [31:0] prev_pc, prev_instr;
    logic        prev_valid;
    int          delivered = 0;

    typedef struct {
        bit          st;
        bit          rd;
        logic [31:0] rpc;
        bit          rdy;
        int          lat;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic model_check(input bit st, input bit rd, input logic [31:0] rpc);
        if (rd) begin
            chk("redir_bubble_valid", 32'(if_id_valid), 32'h0);
            chk("redir_bubble_pc", if_id_pc, 32'h0);
            chk("redir_bubble_instr", if_id_instr, NOP_INSTR_DEFAULT);
            exp_pc = {rpc[31:2], 2'b00};
        end else if (st) begin
            chk("stall_hold_valid", 32'(if_id_valid), 32'(prev_valid));
            chk("stall_hold_pc", if_id_pc, prev_pc);
            chk("stall_hold_instr", if_id_instr, prev_instr);
        end else if (if_id_valid) begin
            chk("stream_pc", if_id_pc, exp_pc);
            chk("stream_instr", if_id_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end else begin
            chk("bubble_pc", if_id_pc, 32'h0);
            chk("bubble_instr", if_id_instr, NOP_INSTR_DEFAULT);
        end
        prev_pc    = if_id_pc;
        prev_instr = if_id_instr;
        prev_valid = if_id_valid;
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc,
                         input bit rdy, input int lat);
        bit          acc;
        logic [31:0] acc_addr;
        stall          = st;
        redirect       = rd;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        imem_rsp_valid = mem_pend && (mem_cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? mem_data : 32'hDEAD_BEEF;
        #1;
        if (st || rd) chk("no_issue_when_held", 32'(imem_req_valid), 32'h0);
        if (mem_pend && !imem_rsp_valid) chk("single_outstanding", 32'(imem_req_valid), 32'h0);
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_addr;
        @(posedge clk);
        if (imem_rsp_valid) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (acc) begin
            mem_pend = 1;
            mem_cnt  = lat - 1;
            mem_data = mem_word(acc_addr);
        end
        @(negedge clk);
        model_check(st, rd, rpc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        mem_pend       = 0;
        repeat (2) @(negedge clk);
        chk("rst_if_id_pc", if_id_pc, 32'h0);
        chk("rst_if_id_instr", if_id_instr, NOP_INSTR_DEFAULT);
        chk("rst_if_id_valid", 32'(if_id_valid), 32'h0);
        chk("rst_imem_addr", imem_addr, RESET_PC_DEFAULT);
        exp_pc     = RESET_PC_DEFAULT;
        prev_pc    = 32'h0;
        prev_instr = NOP_INSTR_DEFAULT;
        prev_valid = 1'b0;
        rst_n      = 1'b1;
    endtask

    initial begin
        //                st rd rpc           rdy lat ev epc           eaddr
        tbl.push_back('{0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h4});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 1, 32'h0,        32'h8});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 1, 32'h4,        32'hC});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 1, 32'h8,        32'h10});
        tbl.push_back('{1, 0, 32'h0,        1, 1, 1, 32'h8,        32'h10});
        tbl.push_back('{1, 0, 32'h0,        1, 1, 1, 32'h8,        32'h10});
        tbl.push_back('{1, 0, 32'h0,        1, 1, 1, 32'h8,        32'h10});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 1, 32'hC,        32'h10});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h14});
        tbl.push_back('{0, 0, 32'h0,        1, 3, 1, 32'h10,       32'h18});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h18});
        tbl.push_back('{0, 1, 32'h100,      1, 1, 0, 32'h0,        32'h100});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h104});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 1, 32'h100,      32'h108});
        tbl.push_back('{1, 1, 32'h203,      1, 1, 0, 32'h0,        32'h200});
        tbl.push_back('{1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h200});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h204});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 1, 32'h200,      32'h208});
        tbl.push_back('{0, 0, 32'h0,        0, 1, 1, 32'h204,      32'h208});
        tbl.push_back('{0, 0, 32'h0,        0, 1, 0, 32'h0,        32'h208});
        tbl.push_back('{0, 0, 32'h0,        0, 1, 0, 32'h0,        32'h208});
        tbl.push_back('{0, 0, 32'h0,        0, 1, 0, 32'h0,        32'h208});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h20C});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 1, 32'h208,      32'h210});
        tbl.push_back('{0, 1, 32'hFFFFFFFC, 1, 1, 0, 32'h0,        32'hFFFFFFFC});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 1, 32'hFFFFFFFC, 32'h4});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 1, 32'h0,        32'h8});

        do_reset();
        foreach (tbl[i]) begin
            cycle(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].rdy, tbl[i].lat);
            chk($sformatf("row%0d_valid", i), 32'(if_id_valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d_pc", i), if_id_pc, tbl[i].epc);
            chk($sformatf("row%0d_instr", i), if_id_instr,
                tbl[i].ev ? mem_word(tbl[i].epc) : NOP_INSTR_DEFAULT);
            chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].eaddr);
        end

        // randomized traffic: stalls, redirects, back-pressure, latency 1..4
        do_reset();
        delivered = 0;
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(99, 0) < 25, $urandom_range(99, 0) < 6, $urandom,
                  $urandom_range(99, 0) < 70, int'($urandom_range(4, 1)));
        end
        chk("random_progress", 32'(delivered > 200), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
